// File: rtl/writeback.sv
// Writeback stage: accepts one instruction at a time, waits for load data when needed,
// and hands a single-cycle register-file write strobe to decode.
package writeback_pkg;
    localparam logic [4:0] RTYPE = 5'd1;
    localparam logic [4:0] ITYPE = 5'd2;
    localparam logic [4:0] STYPE = 5'd3;
    localparam logic [4:0] BTYPE = 5'd4;
    localparam logic [4:0] LTYPE = 5'd5;
    localparam logic [4:0] UTYPE = 5'd6;
    localparam logic [4:0] JTYPE = 5'd7;
endpackage

module writeback
    import writeback_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  stage_i,
    input  logic [4:0]  itype_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] alu_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] mem_i,
    input  logic        mem_valid_i,
    output logic [31:0] wd_o,
    output logic        wd_q_o,
    output logic [4:0]  rd_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [4:0]  rd_q;
    logic        accept;
    logic        writes;
    logic        is_load;
    logic [31:0] wd_sel;

    assign accept  = (state == IDLE) && (stage_i == 3'd4);
    assign is_load = (itype_i == LTYPE);

    always_comb begin
        writes = 1'b0;
        wd_sel = alu_i;
        case (itype_i)
            RTYPE, ITYPE, UTYPE, LTYPE: writes = (rd_i != 5'd0);
            JTYPE: begin
                writes = (rd_i != 5'd0);
                wd_sel = pc_i + 32'd4;
            end
            default: writes = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!writes)      state_nxt = DONE;
                    else if (is_load) state_nxt = WAIT_MEM;
                    else              state_nxt = WRITE;
                end
            end
            // Load data beats the timeout if both land on the last counted cycle.
            WAIT_MEM: begin
                if (mem_valid_i)        state_nxt = WRITE;
                else if (cnt == 8'hFF)  state_nxt = DONE;
            end
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
            rd_q  <= 5'd0;
            wd_o  <= 32'd0;
            rd_o  <= 5'd0;
            err_o <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rd_q <= rd_i;
                        cnt  <= 8'd0;
                        // wd_o/rd_o only move when a write is really coming.
                        if (writes && !is_load) begin
                            wd_o <= wd_sel;
                            rd_o <= rd_i;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_valid_i) begin
                        wd_o <= mem_i;
                        rd_o <= rd_q;
                    end else if (cnt == 8'hFF) begin
                        err_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wd_q_o = (state == WRITE);
    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);
endmodule

// File: tb/tb_writeback.sv
// Bench for writeback: directed vector table, randomized transactions against a
// transaction-level model, and hand-written timeout / reset sequences.
module tb_writeback;
    import writeback_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  stage_i;
    logic [4:0]  itype_i;
    logic [4:0]  rd_i;
    logic [31:0] alu_i, pc_i, mem_i;
    logic        mem_valid_i;
    logic [31:0] wd_o;
    logic        wd_q_o;
    logic [4:0]  rd_o;
    logic        busy_o, done_o, err_o;

    int tests = 0;
    int fails = 0;
    logic [31:0] last_wd = 32'd0;
    logic [4:0]  last_rd = 5'd0;
    bit          err_model = 1'b0;

    writeback dut (
        .clk(clk), .reset(reset), .stage_i(stage_i), .itype_i(itype_i), .rd_i(rd_i),
        .alu_i(alu_i), .pc_i(pc_i), .mem_i(mem_i), .mem_valid_i(mem_valid_i),
        .wd_o(wd_o), .wd_q_o(wd_q_o), .rd_o(rd_o), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction: accept in the current (IDLE) cycle, then watch until done_o.
    // dly = WAIT_MEM cycle index on which mem_valid_i is raised (-1 = never).
    task automatic run_txn(input string nm, input logic [4:0] it, input logic [4:0] r,
                           input logic [31:0] a, input logic [31:0] p, input logic [31:0] m,
                           input int dly, input bit ewr, input logic [31:0] ewd,
                           input int estb, input int edone);
        int nstb = 0, stb_t = -1, done_t = -1;
        logic [31:0] got_wd = 32'd0;
        logic [4:0]  got_rd = 5'd0;
        stage_i = 3'd4; itype_i = it; rd_i = r; alu_i = a; pc_i = p;
        mem_i = $urandom; mem_valid_i = 1'($urandom_range(0, 1));
        @(posedge clk);
        for (int t = 0; t < 300 && done_t < 0; t++) begin
            @(negedge clk);
            if (t == 0) chk({nm, "/busy"}, 32'(busy_o), 32'd1);
            if (wd_q_o) begin nstb++; stb_t = t; got_wd = wd_o; got_rd = rd_o; end
            if (done_o) done_t = t;
            // Inputs other than load data are don't-care while busy.
            stage_i = done_o ? 3'd0 : ($urandom_range(0, 1) ? 3'd4 : 3'($urandom_range(0, 7)));
            itype_i = 5'($urandom); rd_i = 5'($urandom); alu_i = $urandom; pc_i = $urandom;
            mem_valid_i = (it == LTYPE) ? (t == dly) : 1'($urandom_range(0, 1));
            mem_i = (t == dly) ? m : $urandom;
        end
        if (done_t < 0) begin
            fails++;
            $display("FAIL %s/timeout: no done_o within 300 cycles", nm);
        end
        if (ewr) begin last_wd = ewd; last_rd = r; end
        chk({nm, "/strobes"}, 32'(nstb), ewr ? 32'd1 : 32'd0);
        chk({nm, "/strobe_t"}, 32'(stb_t), ewr ? 32'(estb) : 32'hFFFF_FFFF);
        if (ewr) begin
            chk({nm, "/wd"}, got_wd, ewd);
            chk({nm, "/rd"}, 32'(got_rd), 32'(r));
        end
        chk({nm, "/done_t"}, 32'(done_t), 32'(edone));
        mem_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({nm, "/idle_busy"}, 32'(busy_o), 32'd0);
        chk({nm, "/idle_done"}, 32'(done_o), 32'd0);
        chk({nm, "/err"}, 32'(err_o), 32'(err_model));
        chk({nm, "/hold_wd"}, wd_o, last_wd);
        chk({nm, "/hold_rd"}, 32'(rd_o), 32'(last_rd));
    endtask

    typedef struct {
        logic [4:0]  itype;
        logic [4:0]  rd;
        logic [31:0] alu, pc, mem;
        int          dly;
        bit          wr;
        logic [31:0] wd;
        int          stb, dn;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{RTYPE, 5'd5,  32'h0000_00AA, 32'h0,         32'h0,         0,   1, 32'hAA,        0,  1};
        vecs[1]  = '{LTYPE, 5'd7,  32'h111,       32'h0,         32'hDEAD_BEEF, 3,   1, 32'hDEAD_BEEF, 4,  5};
        vecs[2]  = '{JTYPE, 5'd1,  32'h5,         32'hFFFF_FFFC, 32'h0,         0,   1, 32'h0,         0,  1};
        vecs[3]  = '{STYPE, 5'd9,  32'h77,        32'h0,         32'h0,         0,   0, 32'h0,         -1, 0};
        vecs[4]  = '{RTYPE, 5'd0,  32'h99,        32'h0,         32'h0,         0,   0, 32'h0,         -1, 0};
        vecs[5]  = '{ITYPE, 5'd31, 32'h1234_5678, 32'h0,         32'h0,         0,   1, 32'h1234_5678, 0,  1};
        vecs[6]  = '{UTYPE, 5'd2,  32'hABCD_0000, 32'h0,         32'h0,         0,   1, 32'hABCD_0000, 0,  1};
        vecs[7]  = '{BTYPE, 5'd3,  32'h55,        32'h0,         32'h0,         0,   0, 32'h0,         -1, 0};
        vecs[8]  = '{5'd20, 5'd4,  32'h66,        32'h0,         32'h0,         0,   0, 32'h0,         -1, 0};
        vecs[9]  = '{LTYPE, 5'd0,  32'h0,         32'h0,         32'h3333,      0,   0, 32'h0,         -1, 0};
        vecs[10] = '{LTYPE, 5'd3,  32'h0,         32'h0,         32'hCAFE_F00D, 255, 1, 32'hCAFE_F00D, 256, 257};
        vecs[11] = '{LTYPE, 5'd6,  32'h1,         32'h0,         32'h0,         0,   1, 32'h0,         1,  2};

        reset = 1'b1; stage_i = 3'd4; itype_i = RTYPE; rd_i = 5'd1;
        alu_i = 32'h1; pc_i = 32'h0; mem_i = 32'h0; mem_valid_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset/wd",    wd_o,            32'd0);
        chk("reset/rd",    32'(rd_o),       32'd0);
        chk("reset/wd_q",  32'(wd_q_o),     32'd0);
        chk("reset/busy",  32'(busy_o),     32'd0);
        chk("reset/done",  32'(done_o),     32'd0);
        chk("reset/err",   32'(err_o),      32'd0);
        reset = 1'b0; stage_i = 3'd0; mem_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 12; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].itype, vecs[i].rd, vecs[i].alu, vecs[i].pc,
                    vecs[i].mem, vecs[i].dly, vecs[i].wr, vecs[i].wd, vecs[i].stb, vecs[i].dn);

        // Random transactions predicted from the class rules.
        for (int n = 0; n < 60; n++) begin
            logic [4:0]  it, r;
            logic [31:0] a, p, m, ewd;
            int          dly, estb, edn;
            bit          ld, wr;
            it  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(1, 7));
            r   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            a = $urandom; p = $urandom; m = $urandom;
            dly = $urandom_range(0, 10);
            ld  = (it == LTYPE);
            wr  = (it inside {RTYPE, ITYPE, UTYPE, LTYPE, JTYPE}) && (r != 5'd0);
            ewd = (it == JTYPE) ? p + 32'd4 : (ld ? m : a);
            estb = ld ? dly + 1 : 0;
            edn  = wr ? estb + 1 : 0;
            run_txn($sformatf("rnd%0d", n), it, r, a, p, m, dly, wr, ewd, estb, edn);
        end

        // Load that never sees data: 256 WAIT_MEM cycles, then DONE with sticky err.
        err_model = 1'b1;
        run_txn("timeout", LTYPE, 5'd8, 32'h0, 32'h0, 32'h1111, -1, 0, 32'h0, -1, 256);
        run_txn("sticky", RTYPE, 5'd10, 32'hBEEF, 32'h0, 32'h0, 0, 1, 32'hBEEF, 0, 1);

        // Reset in WAIT_MEM aborts; later load data must be ignored.
        stage_i = 3'd4; itype_i = LTYPE; rd_i = 5'd7; mem_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        stage_i = 3'd0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_wait/busy_before", 32'(busy_o), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_wait/wd",   wd_o,        32'd0);
        chk("rst_wait/rd",   32'(rd_o),   32'd0);
        chk("rst_wait/wd_q", 32'(wd_q_o), 32'd0);
        chk("rst_wait/busy", 32'(busy_o), 32'd0);
        chk("rst_wait/done", 32'(done_o), 32'd0);
        chk("rst_wait/err",  32'(err_o),  32'd0);
        reset = 1'b0; mem_valid_i = 1'b1; mem_i = 32'h9999_9999;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_wait/late_valid_wd_q", 32'(wd_q_o), 32'd0);
            chk("rst_wait/late_valid_busy", 32'(busy_o), 32'd0);
        end
        mem_valid_i = 1'b0;
        err_model = 1'b0; last_wd = 32'd0; last_rd = 5'd0;
        run_txn("post_reset", JTYPE, 5'd12, 32'h0, 32'h0000_1000, 32'h0, 0, 1, 32'h0000_1004, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
